phase_table_loader: RTL and testbench



---
 rtl/phase_loader_pkg.sv | 31 +++
 rtl/phase_frame_rx.sv | 129 ++++++++++++
 rtl/phase_table_loader.sv | 77 +++++++
 tb/tb_phase_table_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_loader_pkg.sv
// ============================================================================
// phase_loader_pkg : shared constants, FSM state type and 10 cm focus table
// Revision 1.0
// ============================================================================
`default_nettype none

package phase_loader_pkg;

    localparam int         N_CH        = 17;
    localparam int         PW          = 11;
    localparam int         PERIOD      = 1250;
    localparam int         TIMEOUT_CYC = 50000;
    localparam logic [7:0] HEADER      = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_CHK  = 2'd3
    } rx_state_t;

    // Channel 0 sits in the least significant word.
    localparam logic [N_CH*PW-1:0] DEFAULT_TABLE = {
        11'd1166, 11'd1105, 11'd1028, 11'd980, 11'd962, 11'd820,
        11'd771,  11'd755,  11'd625,  11'd541, 11'd480, 11'd403,
        11'd337,  11'd195,  11'd146,  11'd130, 11'd0
    };

endpackage

`default_nettype wire

// File: rtl/phase_frame_rx.sv
// ============================================================================
// phase_frame_rx : byte-level frame parser with checksum and range validation
// Optional inter-byte timeout: PHASE_LOADER_TIMEOUT_EN. Revision 1.0
// ============================================================================
`default_nettype none

module phase_frame_rx #(
    parameter int N_CH        = phase_loader_pkg::N_CH,
    parameter int PW          = phase_loader_pkg::PW,
    parameter int PERIOD      = phase_loader_pkg::PERIOD,
    parameter int TIMEOUT_CYC = phase_loader_pkg::TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [N_CH*PW-1:0]   rx_table
);
    import phase_loader_pkg::*;

    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] LAST_CH   = CW'(N_CH - 1);
    localparam logic [PW-1:0] MAX_PHASE = PW'(PERIOD - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CW-1:0]        ch;
    logic [7:0]           xor_acc;
    logic [PW-9:0]        hi_bits;
    logic                 fmt_err;
    logic [N_CH*PW-1:0]   rx_buf;
    logic [PW-1:0]        phase_word;
    logic                 timeout;

    assign phase_word = {hi_bits, in_data};
    assign rx_table   = rx_buf;

`ifdef PHASE_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (in_valid || state == ST_IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = (state != ST_IDLE) && !in_valid &&
                     (idle_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            ST_IDLE: if (in_valid && in_data == HEADER) state_nxt = ST_HI;
            ST_HI:   if (in_valid) state_nxt = ST_LO;
            ST_LO:   if (in_valid) state_nxt = (ch == LAST_CH) ? ST_CHK : ST_HI;
            ST_CHK: begin
                if (in_valid) begin
                    state_nxt = ST_IDLE;
                    if (((xor_acc ^ in_data) == 8'h00) && !fmt_err) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Timeout only fires on byte-free cycles, so it never overlaps a checksum verdict.
        if (timeout) begin
            state_nxt = ST_IDLE;
            frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= '0;
            xor_acc <= '0;
            hi_bits <= '0;
            fmt_err <= 1'b0;
            rx_buf  <= '0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == HEADER) begin
                        ch      <= '0;
                        xor_acc <= '0;
                        fmt_err <= 1'b0;
                    end
                end
                ST_HI: begin
                    hi_bits <= in_data[PW-9:0];
                    xor_acc <= xor_acc ^ in_data;
                    if (in_data[7:PW-8] != '0) fmt_err <= 1'b1;
                end
                ST_LO: begin
                    rx_buf[ch*PW +: PW] <= phase_word;
                    xor_acc             <= xor_acc ^ in_data;
                    if (phase_word > MAX_PHASE) fmt_err <= 1'b1;
                    if (ch != LAST_CH) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/phase_table_loader.sv
// ============================================================================
// phase_table_loader : pending/active phase tables, commit at PWM period start
// Optional inter-byte timeout: PHASE_LOADER_TIMEOUT_EN. Revision 1.0
// ============================================================================
`default_nettype none

module phase_table_loader #(
    parameter int N_CH        = phase_loader_pkg::N_CH,
    parameter int PW          = phase_loader_pkg::PW,
    parameter int PERIOD      = phase_loader_pkg::PERIOD,
    parameter int TIMEOUT_CYC = phase_loader_pkg::TIMEOUT_CYC
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 period_start,
    output logic [N_CH*PW-1:0]   phase_flat,
    output logic                 pending,
    output logic                 commit,
    output logic                 frame_ok,
    output logic                 frame_err
);
    import phase_loader_pkg::*;

    logic                 frame_good;
    logic                 frame_bad;
    logic [N_CH*PW-1:0]   rx_table;
    logic [N_CH*PW-1:0]   pend_buf;

    phase_frame_rx #(
        .N_CH        (N_CH),
        .PW          (PW),
        .PERIOD      (PERIOD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk        (CLK),
        .rst_n      (RST_N),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .frame_good (frame_good),
        .frame_bad  (frame_bad),
        .rx_table   (rx_table)
    );

    assign in_ready = RST_N;

    // A frame landing on the same edge as period_start commits the old pend_buf
    // and then becomes the new pending table.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_buf   <= DEFAULT_TABLE;
            phase_flat <= DEFAULT_TABLE;
            pending    <= 1'b0;
            commit     <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_ok  <= frame_good;
            frame_err <= frame_bad;
            commit    <= period_start && pending;
            if (period_start && pending) begin
                phase_flat <= pend_buf;
            end
            if (frame_good) begin
                pend_buf <= rx_table;
                pending  <= 1'b1;
            end else if (period_start) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phase_table_loader.sv
// ============================================================================
// tb_phase_table_loader : randomized frames checked against a frame-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_phase_table_loader;
    import phase_loader_pkg::*;

    logic                 clk;
    logic                 RST_N;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 period_start;
    logic [N_CH*PW-1:0]   phase_flat;
    logic                 pending;
    logic                 commit;
    logic                 frame_ok;
    logic                 frame_err;

    phase_table_loader dut (
        .CLK          (clk),
        .RST_N        (RST_N),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .period_start (period_start),
        .phase_flat   (phase_flat),
        .pending      (pending),
        .commit       (commit),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int DEF_TAB [N_CH] = '{0, 130, 146, 195, 337, 403, 480, 541, 625,
                           755, 771, 820, 962, 980, 1028, 1105, 1166};

    // reference model state
    int          m_active [N_CH];
    int          m_pend   [N_CH];
    int          new_tab  [N_CH];
    bit          m_pending;
    bit          in_frame;
    logic [7:0]  fbytes [$];
    bit          exp_ok, exp_err, exp_commit;

    int          ph [N_CH];
    logic [7:0]  tx_q [$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = DEF_TAB;
        m_pend    = DEF_TAB;
        m_pending = 1'b0;
        in_frame  = 1'b0;
        fbytes.delete();
        exp_ok     = 1'b0;
        exp_err    = 1'b0;
        exp_commit = 1'b0;
    endtask

    // Whole-frame view: buffer 35 bytes after the header, then judge the frame.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic ps);
        bit         good;
        logic [7:0] x;
        exp_ok  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (!in_frame) begin
                if (d == 8'hA5) begin
                    in_frame = 1'b1;
                    fbytes.delete();
                end
            end else begin
                fbytes.push_back(d);
                if (fbytes.size() == 2*N_CH + 1) begin
                    in_frame = 1'b0;
                    good = 1'b1;
                    x = 8'h00;
                    for (int i = 0; i < 2*N_CH; i++) x ^= fbytes[i];
                    if (x != fbytes[2*N_CH]) good = 1'b0;
                    for (int k = 0; k < N_CH; k++) begin
                        new_tab[k] = int'(fbytes[2*k]) * 256 + int'(fbytes[2*k+1]);
                        if (fbytes[2*k] > 8'd7 || new_tab[k] >= PERIOD) good = 1'b0;
                    end
                    exp_ok  = good;
                    exp_err = !good;
                end
            end
        end
        exp_commit = ps && m_pending;
        if (exp_commit) begin
            m_active  = m_pend;
            m_pending = 1'b0;
        end
        if (exp_ok) begin
            m_pend    = new_tab;
            m_pending = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [N_CH*PW-1:0] ef;
        for (int k = 0; k < N_CH; k++) ef[k*PW +: PW] = PW'(m_active[k]);
        check_eq("frame_ok",   frame_ok,   exp_ok);
        check_eq("frame_err",  frame_err,  exp_err);
        check_eq("commit",     commit,     exp_commit);
        check_eq("pending",    pending,    m_pending);
        check_eq("in_ready",   in_ready,   1'b1);
        check_eq("phase_flat", phase_flat, ef);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ps);
        in_valid     = v;
        in_data      = d;
        period_start = ps;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        period_start = 1'b0;
        model_edge(v, d, ps);
        compare_all();
    endtask

    function automatic logic rnd_ps();
        return ($urandom_range(0, 15) == 0);
    endfunction

    task automatic build_frame(input bit bad_chk, input int hi_ch, input logic [7:0] hi_or);
        logic [7:0] x, hb, lb;
        tx_q.delete();
        tx_q.push_back(8'hA5);
        x = 8'h00;
        for (int k = 0; k < N_CH; k++) begin
            hb = 8'(ph[k] >> 8);
            lb = 8'(ph[k]);
            if (k == hi_ch) hb |= hi_or;
            tx_q.push_back(hb);
            tx_q.push_back(lb);
            x ^= hb ^ lb;
        end
        if (bad_chk) x ^= 8'h01;
        tx_q.push_back(x);
    endtask

    task automatic send_frame(input bit rnd, input bit ps_last);
        int   g;
        logic ps;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (rnd) begin
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) step(1'b0, 8'h00, rnd_ps());
            end
            if (ps_last && i == tx_q.size() - 1) ps = 1'b1;
            else                                 ps = rnd ? rnd_ps() : 1'b0;
            step(1'b1, tx_q[i], ps);
        end
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < N_CH; k++) ph[k] = v;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RST_N = 1'b1;
        model_reset();
        compare_all();
    endtask

    initial begin
        int         mode;
        logic [7:0] jb;
        int         errs;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        period_start = 1'b0;
        RST_N        = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // reset table and three idle periods with nothing pending
        check_eq("rst_ch8",  phase_flat[8*PW +: PW],  11'd625);
        check_eq("rst_ch16", phase_flat[16*PW +: PW], 11'd1166);
        for (int p = 0; p < 3; p++) begin
            repeat (40) step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
        end

        // corrupted checksum
        fill(100);
        build_frame(1'b1, -1, 8'h00);
        send_frame(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // out-of-range phase on channel 3
        fill(100);
        ph[3] = 1250;
        build_frame(1'b0, -1, 8'h00);
        check_eq("range_hi_byte", tx_q[7], 8'h04);
        check_eq("range_lo_byte", tx_q[8], 8'hE2);
        send_frame(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_eq("range_ch3_kept", phase_flat[3*PW +: PW], 11'd195);

        // good frame, commit on the next period start
        fill(100);
        build_frame(1'b0, -1, 8'h00);
        send_frame(1'b0, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_eq("commit_ch5", phase_flat[5*PW +: PW], 11'd100);

        // two frames, the second landing with period_start
        fill(100);
        build_frame(1'b0, -1, 8'h00);
        send_frame(1'b0, 1'b0);
        fill(200);
        build_frame(1'b0, -1, 8'h00);
        send_frame(1'b0, 1'b1);
        check_eq("dual_first_ch0", phase_flat[0 +: PW], 11'd100);
        check_eq("dual_pending",   pending, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check_eq("dual_second_ch16", phase_flat[16*PW +: PW], 11'd200);

        // randomized frames: good, bad checksum, out of range, high-bit garbage
        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < N_CH; k++) ph[k] = $urandom_range(0, PERIOD - 1);
            mode = $urandom_range(0, 5);
            if (mode == 1) ph[$urandom_range(0, N_CH - 1)] = $urandom_range(PERIOD, 2047);
            if ($urandom_range(0, 1) == 1) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                step(1'b1, jb, rnd_ps());
            end
            build_frame(mode == 0, (mode == 2) ? int'($urandom_range(0, N_CH - 1)) : -1,
                        8'h08 << $urandom_range(0, 4));
            send_frame(1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) step(1'b0, 8'h00, 1'b1);
        end

        // reset in the middle of a frame with a table pending
        fill(300);
        build_frame(1'b0, -1, 8'h00);
        send_frame(1'b0, 1'b0);
        check_eq("pre_reset_pending", pending, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, tx_q[i], 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        check_eq("post_reset_ch8", phase_flat[8*PW +: PW], 11'd625);

`ifdef PHASE_LOADER_TIMEOUT_EN
        fill(400);
        build_frame(1'b0, -1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, tx_q[i], 1'b0);
        errs = 0;
        for (int c = 0; c < TIMEOUT_CYC + 100; c++) begin
            @(posedge clk);
            #1;
            if (frame_err) errs++;
        end
        check_eq("timeout_err_pulses", errs, 1);
        in_frame = 1'b0;
        send_frame(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
`else
        errs = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
